// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: opcodes, FSM states, ALU codes and mux select encodings for the multi-cycle controller
package riscv_ctrl_pkg;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEM_RD = 4'd3,
    S_MEM_WB = 4'd4,
    S_MEM_WR = 4'd5,
    S_EXEC_R = 4'd6,
    S_EXEC_I = 4'd7,
    S_EXEC_U = 4'd8,
    S_ALUWB  = 4'd9,
    S_BRANCH = 4'd10,
    S_JALR   = 4'd11,
    S_JUMP   = 4'd12,
    S_TRAP   = 4'd13
  } state_t;
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;
  // OP-IMM only honours funct7b5 for SRAI; everything else is a plain funct3 op
  function automatic logic [3:0] alu_op_imm(input logic [2:0] f3, input logic b5);
    return {(f3 == 3'b101) & b5, f3};
  endfunction
endpackage

// File: rtl/mc_branch_cond.sv
// mc_branch_cond: decides branch taken and funct3 legality from ALU SUB flags
module mc_branch_cond (
  input  logic [2:0] funct3,
  input  logic       alu_zero,
  input  logic       alu_lt,
  input  logic       alu_ltu,
  output logic       take,
  output logic       legal
);
  logic base;
  // funct3[2:1] picks the flag, funct3[0] inverts it; 010/011 have no branch meaning
  always_comb begin
    legal = funct3[2:1] != 2'b01;
    base  = funct3[2] ? (funct3[1] ? alu_ltu : alu_lt) : alu_zero;
    take  = legal & (base ^ funct3[0]);
  end
endmodule

// File: rtl/riscv_mc_control.sv
// riscv_mc_control: multi-cycle RV32I Moore controller over shared ALU and unified memory port
module riscv_mc_control
  import riscv_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W     = 4,
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit TRAP_ILLEGAL  = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 alu_zero,
  input  logic                 alu_lt,
  input  logic                 alu_ltu,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_write,
  output logic                 adr_src,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [2:0]           imm_src,
  output logic [ALUCTRL_W-1:0] alu_control,
  output logic                 illegal_instr,
  output logic [3:0]           state_o
);
  state_t state_q, state_d, bad_st;
  logic illegal_q, illegal_d;
  logic rdy, br_take, br_legal;
  logic mem_req_c, mem_write_c, ir_write_c, pc_write_c, reg_write_c;
  logic [3:0] alu_op;
  assign rdy    = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign bad_st = TRAP_ILLEGAL ? S_TRAP : S_FETCH;
  mc_branch_cond u_br (
    .funct3   (funct3),
    .alu_zero (alu_zero),
    .alu_lt   (alu_lt),
    .alu_ltu  (alu_ltu),
    .take     (br_take),
    .legal    (br_legal)
  );
  // state and sticky trap flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end
  // next-state and Moore output decode
  always_comb begin
    state_d     = state_q;
    mem_req_c   = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    reg_write_c = 1'b0;
    adr_src     = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    imm_src     = IMM_I;
    alu_op      = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req_c  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write_c = rdy;
        pc_write_c = rdy;
        state_d    = rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = op == OP_BRANCH ? IMM_B : op == OP_JAL ? IMM_J : IMM_I;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXEC_R;
          OP_IMM:            state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JUMP;
          OP_JALR:           state_d = S_JALR;
          OP_LUI, OP_AUIPC:  state_d = S_EXEC_U;
          default:           state_d = bad_st;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = op == OP_STORE ? IMM_S : IMM_I;
        state_d   = op == OP_STORE ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req_c = 1'b1;
        adr_src   = 1'b1;
        state_d   = rdy ? S_MEM_WB : S_MEM_RD;
      end
      S_MEM_WB: begin
        result_src  = RES_DATA;
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        adr_src     = 1'b1;
        state_d     = rdy ? S_FETCH : S_MEM_WR;
      end
      S_EXEC_R: begin
        alu_src_a = SRCA_RS1;
        alu_op    = {funct7b5, funct3};
        state_d   = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = alu_op_imm(funct3, funct7b5);
        state_d   = S_ALUWB;
      end
      S_EXEC_U: begin
        alu_src_a = op == OP_LUI ? SRCA_ZERO : SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_U;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_RS1;
        alu_op     = ALU_SUB;
        pc_write_c = br_take;
        state_d    = br_legal ? S_FETCH : bad_st;
      end
      S_JALR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        state_d   = S_JUMP;
      end
      S_JUMP: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        pc_write_c = 1'b1;
        state_d    = S_ALUWB;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
    illegal_d = illegal_q | (state_d == S_TRAP);
  end
  assign mem_req       = mem_req_c & ~reset;
  assign mem_write     = mem_write_c & ~reset;
  assign ir_write      = ir_write_c & ~reset;
  assign pc_write      = pc_write_c & ~reset;
  assign reg_write     = reg_write_c & ~reset;
  assign alu_control   = ALUCTRL_W'(alu_op);
  assign illegal_instr = illegal_q;
  assign state_o       = state_q;
endmodule
